// File: rtl/csr_pkg.sv
// Shared CSR numbering, exception codes, csr_op encoding and commit FSM states.
`default_nettype none
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_EUEN   = 14'h02;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_XCHG = 3'd3,
    OP_ERTN = 3'd4
  } csr_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/csr_commit.sv
// WB-stage commit controller: CSR access, exception/ERTN commit and pre-IF redirect.
// Optional interrupt sampling enabled by macro CSR_COMMIT_INT_EN.
`default_nettype none
module csr_commit
  import csr_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ms_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [2:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_mask,
  input  logic [31:0] ms_result,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic        has_int,
  output logic        csr_re,
  output logic [13:0] csr_num,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic        flush_valid,
  input  logic        flush_ready,
  output logic [31:0] flush_target,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  state_e      state_q, state_d;
  logic        ws_valid_q, ws_valid_d;
  logic [31:0] ws_pc_q, ws_pc_d;
  csr_op_e     ws_op_q, ws_op_d;
  logic [13:0] ws_num_q, ws_num_d;
  logic [31:0] ws_mask_q, ws_mask_d;
  logic [31:0] ws_result_q, ws_result_d;
  logic        ws_ex_q, ws_ex_d;
  logic [5:0]  ws_ecode_q, ws_ecode_d;
  logic [8:0]  ws_esub_q, ws_esub_d;
  logic        ws_gr_we_q, ws_gr_we_d;
  logic [4:0]  ws_dest_q, ws_dest_d;
  logic [31:0] flush_target_q, flush_target_d;

  logic commit, int_take, take_ex, take_ertn, csr_acc, csr_wr, rf_en;

`ifdef CSR_COMMIT_INT_EN
  assign int_take = has_int;
`else
  logic unused_has_int;
  assign unused_has_int = has_int;
  assign int_take       = 1'b0;
`endif

  assign ws_allowin = 1'b1;
  assign commit     = ws_valid_q & (state_q == ST_RUN);
  assign take_ex    = commit & (int_take | ws_ex_q);
  assign take_ertn  = commit & ~take_ex & (ws_op_q == OP_ERTN);
  assign csr_acc    = commit & ~take_ex &
                      ((ws_op_q == OP_RD) | (ws_op_q == OP_WR) | (ws_op_q == OP_XCHG));
  assign csr_wr     = csr_acc & (ws_op_q != OP_RD);
  // CSR instructions always write rd with the pre-write CSR value.
  assign rf_en      = commit & ~take_ex & ~take_ertn & (ws_gr_we_q | csr_acc);

  assign csr_re       = csr_acc;
  assign csr_num      = csr_acc ? ws_num_q : 14'd0;
  assign csr_we       = csr_wr;
  assign csr_wmask    = csr_wr ? ((ws_op_q == OP_XCHG) ? ws_mask_q : 32'hFFFF_FFFF) : 32'd0;
  assign csr_wvalue   = csr_wr ? ws_result_q : 32'd0;
  assign wb_ex        = take_ex;
  assign ertn_flush   = take_ertn;
  assign wb_ecode     = take_ex ? (int_take ? ECODE_INT : ws_ecode_q) : 6'd0;
  assign wb_esubcode  = (take_ex & ~int_take) ? ws_esub_q : 9'd0;
  assign wb_pc        = take_ex ? ws_pc_q : 32'd0;
  assign flush_valid  = (state_q == ST_FLUSH);
  assign flush_target = flush_target_q;
  assign rf_we        = rf_en;
  assign rf_waddr     = rf_en ? ws_dest_q : 5'd0;
  assign rf_wdata     = rf_en ? (csr_acc ? csr_rvalue : ws_result_q) : 32'd0;

  always_comb begin
    ws_valid_d  = 1'b0;
    ws_pc_d     = ws_pc_q;
    ws_op_d     = ws_op_q;
    ws_num_d    = ws_num_q;
    ws_mask_d   = ws_mask_q;
    ws_result_d = ws_result_q;
    ws_ex_d     = ws_ex_q;
    ws_ecode_d  = ws_ecode_q;
    ws_esub_d   = ws_esub_q;
    ws_gr_we_d  = ws_gr_we_q;
    ws_dest_d   = ws_dest_q;
    // Offers during FLUSH belong to the squashed path and are dropped.
    if (ms_valid && ws_allowin && state_q == ST_RUN) begin
      ws_valid_d  = 1'b1;
      ws_pc_d     = ms_pc;
      ws_op_d     = csr_op_e'(ms_csr_op);
      ws_num_d    = ms_csr_num;
      ws_mask_d   = ms_csr_mask;
      ws_result_d = ms_result;
      ws_ex_d     = ms_ex;
      ws_ecode_d  = ms_ecode;
      ws_esub_d   = ms_esubcode;
      ws_gr_we_d  = ms_gr_we;
      ws_dest_d   = ms_dest;
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_target_d = flush_target_q;
    case (state_q)
      ST_RUN: begin
        if (take_ex || take_ertn) begin
          state_d        = ST_FLUSH;
          flush_target_d = take_ex ? ex_entry : ertn_entry;
        end
      end
      ST_FLUSH: begin
        if (flush_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_RUN;
      ws_valid_q     <= 1'b0;
      ws_pc_q        <= 32'd0;
      ws_op_q        <= OP_NONE;
      ws_num_q       <= 14'd0;
      ws_mask_q      <= 32'd0;
      ws_result_q    <= 32'd0;
      ws_ex_q        <= 1'b0;
      ws_ecode_q     <= 6'd0;
      ws_esub_q      <= 9'd0;
      ws_gr_we_q     <= 1'b0;
      ws_dest_q      <= 5'd0;
      flush_target_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      ws_valid_q     <= ws_valid_d;
      ws_pc_q        <= ws_pc_d;
      ws_op_q        <= ws_op_d;
      ws_num_q       <= ws_num_d;
      ws_mask_q      <= ws_mask_d;
      ws_result_q    <= ws_result_d;
      ws_ex_q        <= ws_ex_d;
      ws_ecode_q     <= ws_ecode_d;
      ws_esub_q      <= ws_esub_d;
      ws_gr_we_q     <= ws_gr_we_d;
      ws_dest_q      <= ws_dest_d;
      flush_target_q <= flush_target_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_commit.sv
// Self-checking bench for csr_commit: table vectors, redirect corner cases, random vs. model.
`default_nettype none
module tb_csr_commit;

`ifdef CSR_COMMIT_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ms_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [2:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_mask;
  logic [31:0] ms_result;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic        has_int;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        flush_valid;
  logic        flush_ready;
  logic [31:0] flush_target;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  csr_commit dut (
    .clock(clock), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_csr_mask(ms_csr_mask), .ms_result(ms_result), .ms_ex(ms_ex),
    .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .has_int(has_int), .csr_re(csr_re), .csr_num(csr_num),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .csr_rvalue(csr_rvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
    .ex_entry(ex_entry), .ertn_entry(ertn_entry), .flush_valid(flush_valid),
    .flush_ready(flush_ready), .flush_target(flush_target), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] result;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        gr_we;
    logic [4:0]  dest;
  } ins_t;

  typedef struct packed {
    logic        csr_re;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        flush_valid;
    logic [31:0] flush_target;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } out_t;

  typedef struct {
    ins_t        ins;
    logic        hint;
    logic [31:0] rvalue;
    logic        e_csr_we;
    logic [31:0] e_wmask;
    logic [31:0] e_wvalue;
    logic        e_rf_we;
    logic [31:0] e_rf_wdata;
    logic        e_wb_ex;
    logic [5:0]  e_ecode;
    logic        e_ertn;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference: one WB slot plus a redirect-pending flag and its target.
  logic        m_slot_v;
  ins_t        m_slot;
  logic        m_flush;
  logic [31:0] m_target;
  out_t        eo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic out_t model_out();
    out_t o;
    logic commit, intr, ex, ertn, csr;
    o = '0;
    commit = m_slot_v && !m_flush;
    intr   = INT_EN && has_int;
    ex     = commit && (intr || m_slot.ex);
    ertn   = commit && !ex && m_slot.op == 3'd4;
    csr    = commit && !ex && m_slot.op >= 3'd1 && m_slot.op <= 3'd3;
    o.wb_ex = ex;
    o.ertn_flush = ertn;
    if (ex) begin
      o.wb_pc       = m_slot.pc;
      o.wb_ecode    = intr ? 6'h00 : m_slot.ecode;
      o.wb_esubcode = intr ? 9'd0 : m_slot.esub;
    end
    if (csr) begin
      o.csr_re  = 1'b1;
      o.csr_num = m_slot.num;
      if (m_slot.op != 3'd1) begin
        o.csr_we     = 1'b1;
        o.csr_wmask  = (m_slot.op == 3'd3) ? m_slot.mask : 32'hFFFF_FFFF;
        o.csr_wvalue = m_slot.result;
      end
    end
    if (commit && !ex && !ertn && (csr || m_slot.gr_we)) begin
      o.rf_we    = 1'b1;
      o.rf_waddr = m_slot.dest;
      o.rf_wdata = csr ? csr_rvalue : m_slot.result;
    end
    o.flush_valid  = m_flush;
    o.flush_target = m_target;
    return o;
  endfunction

  task automatic sample();
    #3;
    eo = model_out();
    chk("ws_allowin",   32'(ws_allowin),   32'd1);
    chk("csr_re",       32'(csr_re),       32'(eo.csr_re));
    chk("csr_num",      32'(csr_num),      32'(eo.csr_num));
    chk("csr_we",       32'(csr_we),       32'(eo.csr_we));
    chk("csr_wmask",    csr_wmask,         eo.csr_wmask);
    chk("csr_wvalue",   csr_wvalue,        eo.csr_wvalue);
    chk("wb_ex",        32'(wb_ex),        32'(eo.wb_ex));
    chk("ertn_flush",   32'(ertn_flush),   32'(eo.ertn_flush));
    chk("wb_ecode",     32'(wb_ecode),     32'(eo.wb_ecode));
    chk("wb_esubcode",  32'(wb_esubcode),  32'(eo.wb_esubcode));
    chk("wb_pc",        wb_pc,             eo.wb_pc);
    chk("flush_valid",  32'(flush_valid),  32'(eo.flush_valid));
    chk("flush_target", flush_target,      eo.flush_target);
    chk("rf_we",        32'(rf_we),        32'(eo.rf_we));
    chk("rf_waddr",     32'(rf_waddr),     32'(eo.rf_waddr));
    chk("rf_wdata",     rf_wdata,          eo.rf_wdata);
  endtask

  task automatic edge_step();
    @(posedge clock);
    if (reset) begin
      m_slot_v = 1'b0; m_slot = '0; m_flush = 1'b0; m_target = 32'd0;
    end else if (m_flush) begin
      if (flush_ready) m_flush = 1'b0;
      m_slot_v = 1'b0;
    end else begin
      if (eo.wb_ex || eo.ertn_flush) begin
        m_flush  = 1'b1;
        m_target = eo.wb_ex ? ex_entry : ertn_entry;
      end
      m_slot_v = ms_valid;
      if (ms_valid) begin
        m_slot = '{pc: ms_pc, op: ms_csr_op, num: ms_csr_num, mask: ms_csr_mask,
                   result: ms_result, ex: ms_ex, ecode: ms_ecode, esub: ms_esubcode,
                   gr_we: ms_gr_we, dest: ms_dest};
      end
    end
    #1;
  endtask

  task automatic drive(input ins_t i, input logic v);
    ms_valid = v; ms_pc = i.pc; ms_csr_op = i.op; ms_csr_num = i.num;
    ms_csr_mask = i.mask; ms_result = i.result; ms_ex = i.ex; ms_ecode = i.ecode;
    ms_esubcode = i.esub; ms_gr_we = i.gr_we; ms_dest = i.dest;
  endtask

  function automatic ins_t mk(input logic [2:0] op, input logic [13:0] num, input logic [31:0] mask,
                              input logic [31:0] res, input logic ex, input logic [5:0] ec,
                              input logic gw, input logic [4:0] dest);
    ins_t i;
    i = '{pc: 32'h1C00_0000 + 32'(op) * 4, op: op, num: num, mask: mask, result: res,
          ex: ex, ecode: ec, esub: 9'd0, gr_we: gw, dest: dest};
    return i;
  endfunction

  task automatic drain();
    for (int k = 0; k < 4 && m_flush; k++) begin
      flush_ready = 1'b1; sample(); edge_step();
    end
    flush_ready = 1'b0;
  endtask

  vec_t vecs[9];
  int   ex_pulses, fv_cycles, rf_in_flush;

  initial begin
    vecs[0] = '{mk(3'd2, 14'h30, 32'h0, 32'h1234_5678, 1'b0, 6'h0, 1'b1, 5'd5), 1'b0, 32'h0,
                1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 6'h0, 1'b0};
    vecs[1] = '{mk(3'd3, 14'h30, 32'h0000_FFFF, 32'hAAAA_BBBB, 1'b0, 6'h0, 1'b1, 5'd6), 1'b0, 32'h1234_5678,
                1'b1, 32'h0000_FFFF, 32'hAAAA_BBBB, 1'b1, 32'h1234_5678, 1'b0, 6'h0, 1'b0};
    vecs[2] = '{mk(3'd1, 14'h05, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1, 5'd3), 1'b0, 32'hDEAD_BEEF,
                1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'h0, 1'b0};
    vecs[3] = '{mk(3'd0, 14'h00, 32'h0, 32'h0000_0055, 1'b0, 6'h0, 1'b1, 5'd9), 1'b0, 32'h0,
                1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0055, 1'b0, 6'h0, 1'b0};
    vecs[4] = '{mk(3'd0, 14'h00, 32'h0, 32'h0000_0077, 1'b0, 6'h0, 1'b0, 5'd9), 1'b0, 32'h0,
                1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 6'h0, 1'b0};
    vecs[5] = '{mk(3'd4, 14'h00, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 5'd0), 1'b0, 32'h0,
                1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 6'h0, 1'b1};
    vecs[6] = '{mk(3'd2, 14'h30, 32'h0, 32'h1, 1'b1, 6'h0D, 1'b1, 5'd4), 1'b0, 32'h0,
                1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 6'h0D, 1'b0};
    vecs[7] = '{mk(3'd2, 14'h31, 32'h0, 32'h0BAD_F00D, 1'b0, 6'h0, 1'b1, 5'd7), 1'b1, 32'h0000_0042,
                !INT_EN, INT_EN ? 32'h0 : 32'hFFFF_FFFF, INT_EN ? 32'h0 : 32'h0BAD_F00D,
                !INT_EN, INT_EN ? 32'h0 : 32'h0000_0042, INT_EN, 6'h0, 1'b0};
    vecs[8] = '{mk(3'd4, 14'h00, 32'h0, 32'h0, 1'b1, 6'h08, 1'b0, 5'd0), 1'b0, 32'h0,
                1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 6'h08, 1'b0};

    m_slot_v = 1'b0; m_slot = '0; m_flush = 1'b0; m_target = 32'd0; eo = '0;
    reset = 1'b1; drive('0, 1'b0); has_int = 1'b0; csr_rvalue = 32'd0;
    ex_entry = 32'h1C00_8000; ertn_entry = 32'h1C00_0104; flush_ready = 1'b0;
    edge_step(); edge_step();
    reset = 1'b0;
    sample();
    edge_step();

    foreach (vecs[v]) begin
      drive(vecs[v].ins, 1'b1);
      sample(); edge_step();
      drive('0, 1'b0);
      has_int = vecs[v].hint; csr_rvalue = vecs[v].rvalue;
      sample();
      chk($sformatf("v%0d csr_we", v),     32'(csr_we),     32'(vecs[v].e_csr_we));
      chk($sformatf("v%0d csr_wmask", v),  csr_wmask,       vecs[v].e_wmask);
      chk($sformatf("v%0d csr_wvalue", v), csr_wvalue,      vecs[v].e_wvalue);
      chk($sformatf("v%0d rf_we", v),      32'(rf_we),      32'(vecs[v].e_rf_we));
      chk($sformatf("v%0d rf_wdata", v),   rf_wdata,        vecs[v].e_rf_wdata);
      chk($sformatf("v%0d wb_ex", v),      32'(wb_ex),      32'(vecs[v].e_wb_ex));
      chk($sformatf("v%0d wb_ecode", v),   32'(wb_ecode),   32'(vecs[v].e_ecode));
      chk($sformatf("v%0d ertn_flush", v), 32'(ertn_flush), 32'(vecs[v].e_ertn));
      if (v == 0) chk("v0 rf_waddr", 32'(rf_waddr), 32'd5);
      edge_step();
      has_int = 1'b0;
      if (v == 5) begin
        sample();
        chk("ertn flush_target", flush_target, 32'h1C00_0104);
      end
      drain();
    end

    // Syscall with redirect held off for three cycles; younger offers must be dropped.
    ex_pulses = 0; fv_cycles = 0; rf_in_flush = 0;
    ex_entry = 32'h1C00_8000;
    drive('{pc: 32'h1C00_0100, op: 3'd0, num: 14'h0, mask: 32'h0, result: 32'h0, ex: 1'b1,
            ecode: 6'h0B, esub: 9'd0, gr_we: 1'b1, dest: 5'd2}, 1'b1);
    sample(); edge_step();
    drive(mk(3'd0, 14'h0, 32'h0, 32'h1111_1111, 1'b0, 6'h0, 1'b1, 5'd8), 1'b1);
    sample();
    chk("sys wb_pc", wb_pc, 32'h1C00_0100);
    if (wb_ex) ex_pulses++;
    edge_step();
    for (int k = 0; k < 6; k++) begin
      flush_ready = (k == 3);
      if (k >= 4) ms_valid = 1'b0;
      sample();
      if (wb_ex) ex_pulses++;
      if (flush_valid) begin
        fv_cycles++;
        chk("sys flush_target", flush_target, 32'h1C00_8000);
      end
      if (rf_we) rf_in_flush++;
      edge_step();
    end
    flush_ready = 1'b0;
    chk("sys wb_ex pulses", 32'(ex_pulses), 32'd1);
    chk("sys flush_valid cycles", 32'(fv_cycles), 32'd4);
    chk("sys rf_we during flush", 32'(rf_in_flush), 32'd0);

    // Reset while a redirect is pending.
    drive(mk(3'd4, 14'h0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 5'd0), 1'b1);
    sample(); edge_step();
    drive('0, 1'b0);
    sample(); edge_step();
    sample();
    chk("rst pre flush_valid", 32'(flush_valid), 32'd1);
    reset = 1'b1;
    edge_step();
    reset = 1'b0;
    sample();
    chk("rst flush_valid", 32'(flush_valid), 32'd0);
    chk("rst ws_allowin", 32'(ws_allowin), 32'd1);
    chk("rst flush_target", flush_target, 32'd0);
    edge_step();

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      ins_t r;
      r = '{pc: $urandom, op: 3'($urandom_range(0, 5)), num: 14'($urandom), mask: $urandom,
            result: $urandom, ex: ($urandom_range(0, 7) == 0), ecode: 6'($urandom),
            esub: 9'($urandom), gr_we: 1'($urandom), dest: 5'($urandom)};
      drive(r, 1'($urandom));
      has_int     = ($urandom_range(0, 9) == 0);
      csr_rvalue  = $urandom;
      ex_entry    = $urandom;
      ertn_entry  = $urandom;
      flush_ready = 1'($urandom);
      reset       = ($urandom_range(0, 99) == 0);
      sample();
      edge_step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_commit.md
# csr_commit

Writeback-stage commit controller that drives the CSR file's instruction-access and hardware-event ports. It latches one instruction per cycle from MEM, performs CSRRD/CSRWR/CSRXCHG, and raises `wb_ex`/`ertn_flush` with the matching ecode, esubcode and PC. It then holds a redirect request toward pre-IF until that request is accepted. It sits between the MEM→WB pipeline register and the register file, opposite the CSR file.

## Interface
- No parameters.
- Clock is `clock`; reset is `reset`, synchronous and active-high.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `ms_valid` in 1: MEM offers an instruction.
- `ws_allowin` out 1: WB accepts this cycle.
- `ms_pc` in 32: instruction PC.
- `ms_csr_op` in 3: 0 none, 1 CSRRD, 2 CSRWR, 3 CSRXCHG, 4 ERTN.
- `ms_csr_num` in 14: CSR index.
- `ms_csr_mask` in 32: rj value, used as the write mask for XCHG.
- `ms_result` in 32: ALU/load result; this is the rd value (write data) for CSRWR/CSRXCHG.
- `ms_ex` in 1: earlier-stage exception.
- `ms_ecode` in 6: ecode of the earlier-stage exception.
- `ms_esubcode` in 9: esubcode of the earlier-stage exception.
- `ms_gr_we` in 1: GPR write enable.
- `ms_dest` in 5: GPR destination.
- `has_int` in 1: interrupt pending, level.
- `csr_re`, `csr_num`[14], `csr_we`, `csr_wmask`[32], `csr_wvalue`[32]: out; CSR instruction port.
- `csr_rvalue` in 32: CSR read data, combinational.
- `wb_ex`, `ertn_flush` out 1: one-cycle commit pulses.
- `wb_ecode` out 6, `wb_esubcode` out 9, `wb_pc` out 32: exception info to the CSR file.
- `ex_entry`, `ertn_entry` in 32: redirect targets from the CSR file.
- `flush_valid` out 1 / `flush_ready` in 1 / `flush_target` out 32: redirect handshake to pre-IF.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: GPR write port.

## Operation
- **WB register (`ws_*`) load:** loads on `ms_valid & ws_allowin`.
- **WB register clear:** `ws_valid` clears when no load occurs.
- **`ws_allowin`:** is 1 in RUN and in FLUSH.
- **Discard in FLUSH:** any instruction offered while in FLUSH is discarded; `ws_valid` stays 0.
- **Commit condition:** committing = `ws_valid & state==RUN`.
- **Exception take (priority 1, interrupt):** interrupt is taken when `has_int` is sampled at commit. It produces ecode 0x00, esubcode 0.
- **Exception take (priority 2, `ws_ex`):** uses `ws_ecode`/`ws_esubcode`.
- **Exception take, effects:** `wb_ex`=1 and `wb_pc`=`ws_pc`. `csr_we`=0 and `rf_we`=0.
- **ERTN:** op 4 without an exception gives `ertn_flush`=1, and `rf_we`=0.
- **CSRRD:** `csr_re`=1; rd gets `csr_rvalue`.
- **CSRWR:** `csr_we`=1, `csr_wmask`=FFFF_FFFF, `csr_wvalue`=`ws_result`; rd gets the old `csr_rvalue`.
- **CSRXCHG:** same as CSRWR, except `csr_wmask`=`ws_csr_mask`.
- **Other instructions:** `rf_we`=`ws_gr_we`, `rf_wdata`=`ws_result`.
- **FSM RUN→FLUSH:** on a commit with `wb_ex` or `ertn_flush`. `flush_target` is latched as `ex_entry` if `wb_ex`, else `ertn_entry`.
- **FSM FLUSH:** `flush_valid`=1, target stable. FLUSH→RUN on `flush_ready`.
- **Reset:** `state`=RUN, `ws_valid`=0, all `ws_*` fields 0, `flush_target`=0. All outputs read 0 except `ws_allowin`=1.

## Timing
- **Commit outputs:** `csr_*`, `wb_ex`, `ertn_flush` and `rf_*` are combinational from the `ws_*` registers, in the cycle after MEM hand-off.
- **Redirect latency:** `flush_valid` rises 1 cycle after the `wb_ex`/`ertn_flush` pulse.
- **Redirect hold:** `flush_valid` stays high until the cycle `flush_ready`=1, then drops on the next edge. Minimum FLUSH length is 1 cycle.
- **Pulse width:** `wb_ex` and `ertn_flush` pulse exactly once per event, never during FLUSH.
- **Simultaneous load and FLUSH exit:** an instruction offered in the same cycle as `flush_ready` is discarded, since the state is still FLUSH.
- **`has_int` mid-stream:** rising with no valid WB instruction has no effect until the next commit.
- **Exception + ERTN:** exception wins; `ertn_flush`=0.
- **Reset mid-FLUSH:** aborts the redirect; `flush_valid`=0 next cycle.

## Configuration
- Macro `CSR_COMMIT_INT_EN`.
- **Defined:** `has_int` sampling is active as described above.
- **Undefined:** `has_int` is ignored. Only `ws_ex` raises `wb_ex`. The port remains present and unused.

## Structure
- Shared package `csr_pkg` holds:
  - CSR numbers (CRMD 0x00 … TICLR 0x44);
  - the ECODE constants: INT 0x00, ADE 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D;
  - the `ms_csr_op` encoding;
  - FSM state enum {RUN, FLUSH}.
- No sub-module: the FSM and the WB register are inline.

## Test plan
- **CSRWR:** CSRWR num 0x30, `ms_result`=1234_5678, rd=5, old SAVE0=0.
  - `csr_we`=1, mask FFFF_FFFF, value 1234_5678, `rf_wdata`=0, `rf_waddr`=5.
- **CSRXCHG:** CSRXCHG num 0x30, mask 0000_FFFF, `ms_result`=AAAA_BBBB, `csr_rvalue`=1234_5678.
  - `csr_wmask`=0000_FFFF, `rf_wdata`=1234_5678.
- **Syscall + slow redirect:** syscall (`ms_ex`=1, ecode 0x0B) at PC 1C00_0100, `ex_entry`=1C00_8000, `flush_ready` low for 3 cycles.
  - One `wb_ex` pulse, `wb_pc`=1C00_0100.
  - `flush_valid` high 4 cycles, target 1C00_8000.
  - Instructions offered during FLUSH produce no `rf_we`.
- **ERTN:** ERTN with `ertn_entry`=1C00_0104.
  - `ertn_flush` pulse, `flush_target`=1C00_0104, `rf_we`=0.
- **Interrupt vs. CSRWR:** `has_int`=1 while a CSRWR commits.
  - `CSR_COMMIT_INT_EN` defined: `wb_ex` with ecode 0, `csr_we`=0.
  - `CSR_COMMIT_INT_EN` undefined: normal CSRWR.
- **Reset during FLUSH:** `reset` asserted during FLUSH.
  - Next cycle: `flush_valid`=0, `ws_allowin`=1, state RUN.
